// File: rtl/sram_ctrl.sv
// ---------------------------------------------------------------------------
// sram_ctrl
// Initiator-side controller for a 16-bit asynchronous SRAM with active-low
// strobes (IS61 style). Each accepted single-cycle request is expanded into a
// SETUP -> STROBE (WAIT_CYCLES+1 cycles) -> HOLD -> IDLE pin sequence. Only one
// transaction is in flight; requests arriving while busy are dropped.
//
// Ports
//   Clk        system clock, all state changes on the rising edge
//   Reset      synchronous active-high reset
//   req        request valid, sampled only while ready=1
//   req_wr     1 = write, 0 = read
//   req_addr   word address
//   req_wdata  write data
//   req_be     byte enables, [1] = upper byte, [0] = lower byte
//   ready      controller idle, a request is taken this cycle if req=1
//   done       one-cycle completion pulse (rdata valid for reads)
//   rdata      last read data, held until the next read completes
//   A          SRAM address
//   I_O        SRAM data bus, driven only while a write is in progress
//   CE,UB,LB   chip / upper-byte / lower-byte enables, active-low
//   OE,WE      output / write enables, active-low
// ---------------------------------------------------------------------------
module sram_ctrl #(
    parameter int ADDR_W      = 20,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              req,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [1:0]        req_be,
    output logic              ready,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] A,
    inout  wire  [DATA_W-1:0] I_O,
    output logic              CE,
    output logic              UB,
    output logic              LB,
    output logic              OE,
    output logic              WE
);

    localparam int HALF  = DATA_W / 2;
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD
    } state_t;

    state_t             state;
    logic               is_write;
    logic [1:0]         be_q;
    logic [DATA_W-1:0]  wdata_q;
    logic               drive;
    logic [CNT_W-1:0]   strobe_cnt;

    assign ready = (state == IDLE);

    // The bus is only ever driven from a registered enable that is set for
    // writes, so it can never overlap a cycle where OE is low.
    assign I_O = drive ? wdata_q : {DATA_W{1'bz}};

    // Sequencer. Every pin is registered and takes the value belonging to
    // the state being entered. strobe_cnt counts the extra strobe cycles so
    // the strobe lasts WAIT_CYCLES+1 cycles. Read data is captured on the
    // edge that leaves the final strobe cycle, while OE is still low, and
    // only the enabled byte lanes are overwritten.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= IDLE;
            CE         <= 1'b1;
            OE         <= 1'b1;
            WE         <= 1'b1;
            UB         <= 1'b1;
            LB         <= 1'b1;
            A          <= '0;
            drive      <= 1'b0;
            done       <= 1'b0;
            rdata      <= '0;
            is_write   <= 1'b0;
            be_q       <= 2'b00;
            wdata_q    <= '0;
            strobe_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (req) begin
                        state    <= SETUP;
                        is_write <= req_wr;
                        be_q     <= req_be;
                        wdata_q  <= req_wdata;
                        A        <= req_addr;
                        CE       <= 1'b0;
                        UB       <= ~req_be[1];
                        LB       <= ~req_be[0];
                        OE       <= req_wr;
                        WE       <= 1'b1;
                        drive    <= req_wr;
                    end
                end
                SETUP: begin
                    state      <= STROBE;
                    strobe_cnt <= '0;
                    WE         <= ~is_write;
                end
                STROBE: begin
                    if (strobe_cnt == CNT_W'(WAIT_CYCLES)) begin
                        state <= HOLD;
                        done  <= 1'b1;
                        WE    <= 1'b1;
                        if (!is_write) begin
                            OE <= 1'b1;
                            CE <= 1'b1;
                            if (be_q[1]) rdata[DATA_W-1:HALF] <= I_O[DATA_W-1:HALF];
                            if (be_q[0]) rdata[HALF-1:0]      <= I_O[HALF-1:0];
                        end
                    end else begin
                        strobe_cnt <= strobe_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    CE    <= 1'b1;
                    OE    <= 1'b1;
                    WE    <= 1'b1;
                    UB    <= 1'b1;
                    LB    <= 1'b1;
                    drive <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sram_ctrl
// Bench for sram_ctrl. The main instance (WAIT_CYCLES=1) talks to a small
// behavioural SRAM; a transaction-level model predicts every output from the
// number of cycles since a request was accepted. A second instance with
// WAIT_CYCLES=3 checks the longer strobe timing.
// ---------------------------------------------------------------------------
module tb_sram_ctrl;

    localparam int WAIT = 1;
    localparam int N    = WAIT + 1;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        req;
    logic        req_wr;
    logic [19:0] req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  req_be;
    logic        ready;
    logic        done;
    logic [15:0] rdata;
    logic [19:0] A;
    wire  [15:0] io_bus;
    logic        CE, UB, LB, OE, WE;

    logic        req3;
    logic        ready3, done3;
    logic [15:0] rdata3;
    logic [19:0] A3;
    wire  [15:0] io3;
    logic        CE3, UB3, LB3, OE3, WE3;

    int checks = 0;
    int passes = 0;
    bit checking = 1'b0;

    int busy_count = 0;
    int we_count   = 0;
    int done_count = 0;

    always #5 Clk = ~Clk;

    sram_ctrl #(.ADDR_W(20), .DATA_W(16), .WAIT_CYCLES(WAIT)) dut (
        .Clk(Clk), .Reset(Reset), .req(req), .req_wr(req_wr), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_be(req_be), .ready(ready), .done(done),
        .rdata(rdata), .A(A), .I_O(io_bus), .CE(CE), .UB(UB), .LB(LB), .OE(OE), .WE(WE)
    );

    sram_ctrl #(.ADDR_W(20), .DATA_W(16), .WAIT_CYCLES(3)) dut3 (
        .Clk(Clk), .Reset(Reset), .req(req3), .req_wr(1'b0), .req_addr(20'h00005),
        .req_wdata(16'h0000), .req_be(2'b11), .ready(ready3), .done(done3),
        .rdata(rdata3), .A(A3), .I_O(io3), .CE(CE3), .UB(UB3), .LB(LB3), .OE(OE3), .WE(WE3)
    );

    // Behavioural SRAM for the main instance: drives the bus while selected
    // for reading, stores enabled bytes on every edge where WE is low.
    logic [15:0] sram [0:255];
    assign io_bus = (!CE && !OE && WE) ? sram[A[7:0]] : 16'hzzzz;
    always @(posedge Clk) begin
        if (!CE && !WE) begin
            if (!UB) sram[A[7:0]][15:8] <= io_bus[15:8];
            if (!LB) sram[A[7:0]][7:0]  <= io_bus[7:0];
        end
    end

    // Read-only SRAM for the long-strobe instance.
    logic [15:0] sram3 [0:255];
    assign io3 = (!CE3 && !OE3 && WE3) ? sram3[A3[7:0]] : 16'hzzzz;

    // Transaction-level reference: m_ph is the number of cycles since the
    // accepting edge (0 = idle), so phase 1 is setup, 2..N+1 strobe, N+2 hold.
    int          m_ph = 0;
    logic        m_wr = 1'b0;
    logic [19:0] m_addr = '0;
    logic [19:0] m_a = '0;
    logic [15:0] m_wdata = '0;
    logic [1:0]  m_be = 2'b00;
    logic [15:0] m_rdata = '0;
    logic [15:0] ref_mem [0:255];

    always @(posedge Clk) begin
        if (m_wr && m_ph >= 2 && m_ph <= N + 1) begin
            if (m_be[1]) ref_mem[m_addr[7:0]][15:8] = m_wdata[15:8];
            if (m_be[0]) ref_mem[m_addr[7:0]][7:0]  = m_wdata[7:0];
        end
        if (Reset) begin
            m_ph    = 0;
            m_rdata = '0;
            m_a     = '0;
        end else if (m_ph == 0) begin
            if (req) begin
                m_wr    = req_wr;
                m_addr  = req_addr;
                m_a     = req_addr;
                m_wdata = req_wdata;
                m_be    = req_be;
                m_ph    = 1;
            end
        end else begin
            if (m_ph == N + 1 && !m_wr) begin
                if (m_be[1]) m_rdata[15:8] = ref_mem[m_addr[7:0]][15:8];
                if (m_be[0]) m_rdata[7:0]  = ref_mem[m_addr[7:0]][7:0];
            end
            m_ph = (m_ph == N + 2) ? 0 : m_ph + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [19:0] act, input logic [19:0] exp);
        checks++;
        if (act !== exp) $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else passes++;
    endtask

    // Per-cycle comparison of every meaningful output against the model.
    bit m_busy, m_set, m_strobe, m_hold;
    always @(negedge Clk) begin
        if (checking) begin
            m_busy   = (m_ph != 0);
            m_set    = (m_ph >= 1 && m_ph <= N + 1);
            m_strobe = (m_ph >= 2 && m_ph <= N + 1);
            m_hold   = (m_ph == N + 2);
            checkOutput("ready", ready, m_ph == 0);
            checkOutput("done", done, m_hold);
            checkOutput("rdata", rdata, m_rdata);
            checkOutput("A", A, m_a);
            checkOutput("CE", CE, !m_busy || (m_hold && !m_wr));
            checkOutput("OE", OE, m_wr || !m_set);
            checkOutput("WE", WE, !(m_wr && m_strobe));
            if (!m_busy || m_set || m_wr) begin
                checkOutput("UB", UB, m_busy ? !m_be[1] : 1'b1);
                checkOutput("LB", LB, m_busy ? !m_be[0] : 1'b1);
            end
            if (m_busy && m_wr) checkOutput("I_O_wdata", io_bus, m_wdata);
        end
    end

    always @(negedge Clk) begin
        if (!ready) busy_count++;
        if (!WE)    we_count++;
        if (done)   done_count++;
    end

    // One request: waits for idle, pulses req for one cycle, optionally
    // fires an ignored write 0x00005 <- 0x0000 during the strobe, then waits
    // for completion and reports busy / WE-low / done cycle counts.
    task automatic applyStimulus(input logic wr, input logic [19:0] addr, input logic [15:0] wdata,
                                 input logic [1:0] be, input bit spurious,
                                 output int busy_c, output int we_c, output int done_c);
        int n;
        int b0, w0, d0;
        @(negedge Clk);
        n = 0;
        while (!ready && n < 50) begin @(negedge Clk); n++; end
        checkOutput("ready_before_req", ready, 1'b1);
        b0 = busy_count; w0 = we_count; d0 = done_count;
        req = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wdata; req_be = be;
        @(negedge Clk);
        req = 1'b0;
        if (spurious) begin
            @(negedge Clk);
            req = 1'b1; req_wr = 1'b1; req_addr = 20'h00005; req_wdata = 16'h0000; req_be = 2'b11;
            @(negedge Clk);
            req = 1'b0;
        end
        n = 0;
        while (!ready && n < 50) begin @(negedge Clk); n++; end
        checkOutput("ready_after_txn", ready, 1'b1);
        #1;
        busy_c = busy_count - b0;
        we_c   = we_count - w0;
        done_c = done_count - d0;
    endtask

    initial begin
        int bc, wc, dc, d0, oe_low, done_at, n;
        logic [19:0] ra;
        for (int i = 0; i < 256; i++) begin
            sram[i] = 16'h0000; ref_mem[i] = 16'h0000; sram3[i] = 16'h0000;
        end
        sram3[5] = 16'hBEEF;
        Reset = 1'b1; req = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0; req_be = 2'b00;
        req3 = 1'b0;

        // Reset held for two cycles.
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        checking = 1'b1;
        checkOutput("reset_strobes", {CE, OE, WE, UB, LB}, 5'b11111);
        checkOutput("reset_ready", ready, 1'b1);
        checkOutput("reset_done", done, 1'b0);
        checkOutput("reset_rdata", rdata, 16'h0000);
        Reset = 1'b0;

        // Write then read back.
        applyStimulus(1'b1, 20'h00005, 16'hBEEF, 2'b11, 1'b0, bc, wc, dc);
        checkOutput("wr_busy_cycles", bc, 4);
        checkOutput("wr_we_low_cycles", wc, 2);
        checkOutput("wr_done_pulses", dc, 1);
        applyStimulus(1'b0, 20'h00005, 16'h0000, 2'b11, 1'b0, bc, wc, dc);
        checkOutput("rd_busy_cycles", bc, 4);
        checkOutput("rd_we_low_cycles", wc, 0);
        checkOutput("rd_rdata_beef", rdata, 16'hBEEF);

        // Upper-byte-only write merges into an existing word.
        applyStimulus(1'b1, 20'h00006, 16'h1234, 2'b11, 1'b0, bc, wc, dc);
        applyStimulus(1'b1, 20'h00006, 16'hAB00, 2'b10, 1'b0, bc, wc, dc);
        applyStimulus(1'b0, 20'h00006, 16'h0000, 2'b11, 1'b0, bc, wc, dc);
        checkOutput("byte_merge_rdata", rdata, 16'hAB34);

        // Request during the strobe is ignored.
        applyStimulus(1'b0, 20'h00005, 16'h0000, 2'b11, 1'b1, bc, wc, dc);
        checkOutput("ignored_req_done_pulses", dc, 1);
        checkOutput("ignored_req_we_low", wc, 0);
        applyStimulus(1'b0, 20'h00005, 16'h0000, 2'b11, 1'b0, bc, wc, dc);
        checkOutput("ignored_req_readback", rdata, 16'hBEEF);

        // Mid-idle reset clears rdata.
        @(negedge Clk);
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        checkOutput("midreset_rdata", rdata, 16'h0000);
        checkOutput("midreset_ready", ready, 1'b1);
        Reset = 1'b0;

        // Reset in the middle of a write strobe.
        @(negedge Clk);
        d0 = done_count;
        req = 1'b1; req_wr = 1'b1; req_addr = 20'h00007; req_wdata = 16'h5555; req_be = 2'b11;
        @(negedge Clk);
        req = 1'b0;
        @(negedge Clk);
        checkOutput("strobe_we_low", WE, 1'b0);
        Reset = 1'b1;
        @(negedge Clk);
        checkOutput("abort_we", WE, 1'b1);
        checkOutput("abort_ready", ready, 1'b1);
        checkOutput("abort_done", done, 1'b0);
        Reset = 1'b0;
        repeat (4) @(negedge Clk);
        checkOutput("abort_no_done_pulse", done_count - d0, 0);

        // Randomised traffic, including empty byte enables and ignored requests.
        for (int t = 0; t < 60; t++) begin
            ra = 20'($urandom) & 20'hFFF0F;
            applyStimulus(1'($urandom), ra, 16'($urandom), 2'($urandom), 1'($urandom),
                          bc, wc, dc);
            checkOutput("rand_done_pulses", dc, 1);
            repeat ($urandom_range(0, 2)) @(negedge Clk);
        end

        // Long strobe on the WAIT_CYCLES=3 instance.
        @(negedge Clk);
        n = 0;
        while (!ready3 && n < 50) begin @(negedge Clk); n++; end
        req3 = 1'b1;
        oe_low = 0;
        done_at = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge Clk);
            if (k == 1) req3 = 1'b0;
            if (!OE3) oe_low++;
            if (done3 && done_at == 0) done_at = k - 1;
        end
        checkOutput("w3_oe_low_cycles", oe_low, 5);
        checkOutput("w3_done_latency", done_at, 5);
        checkOutput("w3_rdata", rdata3, 16'hBEEF);
        checkOutput("w3_ready", ready3, 1'b1);

        checking = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
